// File: rtl/bnn_pkg.sv
// Shared types and constants for the binarized CNN layer sequencer.
package bnn_pkg;

  localparam int N_CLASS = 10;
  localparam int CLS_W   = 4;
  localparam int SCORE_W = 17;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV1,
    ST_CONV2,
    ST_FC,
    ST_ARGMAX,
    ST_OUT,
    ST_ERR
  } seq_state_t;

  localparam logic [1:0] LAYER_NONE  = 2'd0;
  localparam logic [1:0] LAYER_CONV1 = 2'd1;
  localparam logic [1:0] LAYER_CONV2 = 2'd2;
  localparam logic [1:0] LAYER_FC    = 2'd3;

endpackage

// File: rtl/bnn_argmax_scan.sv
// Serial running-max over the fc scores, one index per cycle.
// Index 0 loads unconditionally; later indices win only on a strictly
// greater signed score, so ties keep the lower index.
module bnn_argmax_scan #(
  parameter int N_CLASS = 10,
  parameter int CLS_W   = 4,
  parameter int SCORE_W = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [SCORE_W-1:0] score,
  output logic [CLS_W-1:0]          idx,
  output logic [CLS_W-1:0]          best_idx,
  output logic                      last
);

  logic                      running_q;
  logic [CLS_W-1:0]          step_q;
  logic [CLS_W-1:0]          best_idx_q;
  logic signed [SCORE_W-1:0] best_val_q;

  function automatic logic beats(input logic signed [SCORE_W-1:0] cand,
                                 input logic signed [SCORE_W-1:0] best);
    return cand > best;
  endfunction

  assign idx      = running_q ? step_q : '0;
  assign last     = running_q && (step_q == CLS_W'(N_CLASS - 1));
  assign best_idx = best_idx_q;

  // Step counter and best value/index registers for one scan pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q  <= 1'b0;
      step_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      step_q    <= '0;
    end else if (running_q) begin
      if ((step_q == '0) || beats(score, best_val_q)) begin
        best_val_q <= score;
        best_idx_q <= step_q;
      end
      if (last) begin
        running_q <= 1'b0;
        step_q    <= '0;
      end else begin
        step_q <= step_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Top-level scheduler: accepts an image, runs conv1 -> conv2 -> fc with a
// per-layer timeout, scans the fc scores for the winning class and holds it
// on a valid/ready output.
module bnn_layer_sequencer #(
  parameter int N_CLASS     = 10,
  parameter int SCORE_W     = 17,
  parameter int CLS_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_busy,
  input  logic                      image_in_valid,
  output logic                      image_in_ready,
  output logic                      img_load,
  output logic                      conv1_start,
  input  logic                      conv1_done,
  output logic                      conv2_start,
  input  logic                      conv2_done,
  output logic                      fc_start,
  input  logic                      fc_done,
  output logic [CLS_W-1:0]          fc_score_idx,
  input  logic signed [SCORE_W-1:0] fc_score,
  output logic                      class_out_valid,
  input  logic                      class_out_ready,
  output logic [CLS_W-1:0]          class_out,
  output logic                      err,
  output logic [1:0]                err_layer,
  input  logic                      clear_err
);
  import bnn_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             alive_q;
  logic             err_q;
  logic [1:0]       err_layer_q;
  logic [1:0]       timeout_layer;
  logic             in_layer, layer_first, timeout_hit;
  logic             scan_start, scan_last;

  assign in_layer    = (state_q == ST_CONV1) || (state_q == ST_CONV2) || (state_q == ST_FC);
  assign layer_first = (cnt_q == '0);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign err         = err_q;
  assign err_layer   = err_layer_q;

  bnn_argmax_scan #(
    .N_CLASS (N_CLASS),
    .CLS_W   (CLS_W),
    .SCORE_W (SCORE_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (scan_start),
    .score    (fc_score),
    .idx      (fc_score_idx),
    .best_idx (class_out),
    .last     (scan_last)
  );

  // Next-state and strobe decode; done wins over a same-cycle timeout.
  always_comb begin
    state_d         = state_q;
    image_in_ready  = 1'b0;
    img_load        = 1'b0;
    conv1_start     = 1'b0;
    conv2_start     = 1'b0;
    fc_start        = 1'b0;
    class_out_valid = 1'b0;
    scan_start      = 1'b0;
    timeout_layer   = LAYER_NONE;
    case (state_q)
      ST_IDLE: begin
        image_in_ready = alive_q && !cfg_busy;
        if (image_in_ready && image_in_valid) begin
          img_load = 1'b1;
          state_d  = ST_CONV1;
        end
      end
      ST_CONV1: begin
        conv1_start = layer_first;
        if (!layer_first && conv1_done) begin
          state_d = ST_CONV2;
        end else if (timeout_hit) begin
          state_d       = ST_ERR;
          timeout_layer = LAYER_CONV1;
        end
      end
      ST_CONV2: begin
        conv2_start = layer_first;
        if (!layer_first && conv2_done) begin
          state_d = ST_FC;
        end else if (timeout_hit) begin
          state_d       = ST_ERR;
          timeout_layer = LAYER_CONV2;
        end
      end
      ST_FC: begin
        fc_start = layer_first;
        if (!layer_first && fc_done) begin
          state_d    = ST_ARGMAX;
          scan_start = 1'b1;
        end else if (timeout_hit) begin
          state_d       = ST_ERR;
          timeout_layer = LAYER_FC;
        end
      end
      ST_ARGMAX: begin
        if (scan_last) state_d = ST_OUT;
      end
      ST_OUT: begin
        class_out_valid = 1'b1;
        if (class_out_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (clear_err) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; alive_q keeps image_in_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Per-layer cycle counter, cleared on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!in_layer || (state_d != state_q)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky error flag and failing-layer code, cleared only by clear_err in ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      err_layer_q <= LAYER_NONE;
    end else if ((state_q == ST_ERR) && clear_err) begin
      err_q       <= 1'b0;
      err_layer_q <= LAYER_NONE;
    end else if (timeout_layer != LAYER_NONE) begin
      err_q       <= 1'b1;
      err_layer_q <= timeout_layer;
    end
  end

endmodule

// File: doc/bnn_layer_sequencer.md
Name: bnn_layer_sequencer

Overview:
- Top-level scheduler for the binarized CNN pipeline: accepts one image per handshake and runs conv1 → conv2 → fc in sequence.
- Reads the 10 fc scores serially, computes the winning class by argmax, and presents it on a valid/ready output.
- Blocks new images while parameter memories are being loaded.
- Sits between the external image/class interfaces and the conv1, conv2 and fc engines.

Parameters:
- N_CLASS, 10, number of fc output scores scanned.
- SCORE_W, 17, width of each signed fc score.
- CLS_W, 4, width of class index (must satisfy 2**CLS_W >= N_CLASS).
- TIMEOUT_CYC, 4096, maximum cycles allowed per layer before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_busy  in  1  parameter/weight load in progress (kernel_layer or offset_layer nonzero)
- image_in_valid  in  1  image present on bus
- image_in_ready  out  1  sequencer can accept an image
- img_load  out  1  one-cycle strobe: engine latches image bus
- conv1_start  out  1  one-cycle start strobe for conv1
- conv1_done  in  1  conv1 complete
- conv2_start  out  1  one-cycle start strobe for conv2
- conv2_done  in  1  conv2 complete
- fc_start  out  1  one-cycle start strobe for fc
- fc_done  in  1  fc complete
- fc_score_idx  out  CLS_W  score read index
- fc_score  in  SCORE_W  signed score at fc_score_idx, combinational same-cycle read
- class_out_valid  out  1  class result valid
- class_out_ready  in  1  consumer accepts class
- class_out  out  CLS_W  winning class index
- err  out  1  layer timeout occurred (sticky)
- err_layer  out  2  failing layer: 1=conv1, 2=conv2, 3=fc, 0=none
- clear_err  in  1  leave ERR state, return to IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all outputs 0, including image_in_ready, strobes, class_out, err and err_layer; counters 0.
- States: IDLE, CONV1, CONV2, FC, ARGMAX, OUT, ERR.
- IDLE:
  - image_in_ready = !cfg_busy.
  - On image_in_valid && image_in_ready, assert img_load that cycle and go to CONV1.
  - If cfg_busy rises in the same cycle as image_in_valid, no accept occurs.
- CONV1, CONV2, FC (one state per layer):
  - The start strobe for the layer is high only in the first cycle of the state.
  - The matching done input is ignored in that first cycle and honored from the second cycle onward.
  - On done: move to the next layer state; from FC, move to ARGMAX.
  - Done inputs belonging to other layers are ignored.
- Timeout:
  - A per-layer cycle counter clears on state entry.
  - If the counter reaches TIMEOUT_CYC-1 with no done, go to ERR.
  - err goes to 1 and err_layer is set to the layer code.
  - If done arrives in the same cycle the counter reaches TIMEOUT_CYC-1, done wins.
- ARGMAX:
  - fc_score_idx steps 0..N_CLASS-1, one index per cycle (N_CLASS cycles).
  - Index 0 loads best value and best index unconditionally.
  - Later indices replace the best only if fc_score > best (signed compare). Ties keep the lower index.
  - After the last index, go to OUT with class_out = best index.
- OUT:
  - class_out_valid=1 and class_out stay stable until class_out_ready.
  - On the handshake cycle, drop valid next cycle and return to IDLE; image_in_ready may be 1 in that cycle.
- ERR:
  - image_in_ready=0 and all strobes 0.
  - clear_err → IDLE and err/err_layer clear. Only reset or clear_err leave ERR.
- cfg_busy outside IDLE: no effect (loads are only legal between images).
- Latency, handshake to class_out_valid: 1 + T1 + T2 + T3 + N_CLASS cycles, where Tn is cycles from layer entry to done inclusive (minimum 2 each).
- fc_score_idx holds 0 outside ARGMAX.

Decomposition:
- Shared package bnn_pkg holds:
  - state enum seq_state_t;
  - err_layer codes LAYER_NONE/CONV1/CONV2/FC;
  - N_CLASS and CLS_W constants;
  - typedef score_t = logic signed [SCORE_W-1:0].
- Sub-module bnn_argmax_scan: serial running max with a start input, step counter, best value/index registers and a last flag.

Test Plan:
- Nominal run: scores {5,-3,9,9,0,-17,2,1,8,-1}, done after 3/4/5 cycles → class_out=2, valid at cycle 1+3+4+5+10=23 after accept.
- All scores negative {-9,-2,-2,-40,...,-50} → class_out=1 (tie keeps lower index); valid held 7 cycles with ready=0, class_out stable throughout.
- cfg_busy=1 with image_in_valid=1 → image_in_ready=0, no img_load. cfg_busy falls → accept next cycle.
- conv2_done never asserted, TIMEOUT_CYC=16 → ERR after 16 cycles in CONV2, err=1, err_layer=2. clear_err → IDLE, err=0.
- Spurious conv1_done in the conv1_start cycle and fc_done during CONV2 → both ignored, sequence unchanged.
- rst_n low mid-ARGMAX → all outputs 0 immediately. After release, a new image runs correctly.
